// File: rtl/lab7_soc_sysid_checker.sv
// lab7_soc_sysid_checker
// Reads the system ID word (slave address 0) and the timestamp word
// (slave address 1) over an Avalon-MM master port and compares them
// against the expected constants.
//
// Optional feature macro: LAB7_SOC_SYSID_CHK_TIMEOUT_EN
//   defined   -> a stall watchdog aborts a read after TIMEOUT_CYCLES
//                consecutive waitrequest cycles (timeout=1, both ok flags 0)
//   undefined -> no watchdog; a stall waits indefinitely, timeout stays 0
//
// Ports
//   clock           in   single clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   start           in   one-cycle pulse requesting a check sequence
//   avm_address     out  Avalon-MM word address (0 = ID, 1 = timestamp)
//   avm_read        out  Avalon-MM read request
//   avm_readdata    in   read data, valid when avm_read=1 and waitrequest=0
//   avm_waitrequest in   slave stall
//   busy            out  high in RD_ID, RD_TS and FIN
//   done            out  one-cycle pulse when a sequence completes
//   id_ok, ts_ok    out  comparison results, held until next completion
//   id_value        out  captured ID word
//   ts_value        out  captured timestamp word
//   timeout         out  last sequence aborted on a stall
module lab7_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1522343701,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        read_r, read_s;
    logic        addr_r, addr_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        id_ok_r, id_ok_s;
    logic        ts_ok_r, ts_ok_s;
    logic [31:0] id_value_r, id_value_s;
    logic [31:0] ts_value_r, ts_value_s;
    logic        timeout_r, timeout_s;
    logic        stall_hit_s;

`ifdef LAB7_SOC_SYSID_CHK_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] stall_cnt_r, stall_cnt_s;

    // Watchdog: counts consecutive stalled read cycles, fires on the last one
    always_comb begin
        stall_hit_s = 1'b0;
        stall_cnt_s = 16'd0;
        if (read_r && avm_waitrequest) begin
            if (({1'b0, stall_cnt_r} + 17'd1) >= TIMEOUT_LIMIT) begin
                stall_hit_s = 1'b1;
                stall_cnt_s = 16'd0;
            end else begin
                stall_cnt_s = stall_cnt_r + 16'd1;
            end
        end else begin
            stall_cnt_s = 16'd0;
        end
    end

    // Stall counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= 16'd0;
        end else begin
            stall_cnt_r <= stall_cnt_s;
        end
    end
`else
    assign stall_hit_s = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_s    = state_r;
        read_s     = read_r;
        addr_s     = addr_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        id_ok_s    = id_ok_r;
        ts_ok_s    = ts_ok_r;
        id_value_s = id_value_r;
        ts_value_s = ts_value_r;
        timeout_s  = timeout_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = RD_ID;
                    read_s    = 1'b1;
                    addr_s    = 1'b0;
                    busy_s    = 1'b1;
                    timeout_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    if (state_r == RD_ID) begin
                        id_value_s = avm_readdata;
                        state_s    = RD_TS;
                        addr_s     = 1'b1;
                        read_s     = 1'b1;
                    end else begin
                        ts_value_s = avm_readdata;
                        state_s    = FIN;
                        addr_s     = 1'b0;
                        read_s     = 1'b0;
                    end
                end else if (stall_hit_s) begin
                    // Abort: captured words keep their previous values
                    state_s   = FIN;
                    read_s    = 1'b0;
                    addr_s    = 1'b0;
                    timeout_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            FIN: begin
                // done and the ok flags are registered on leaving FIN so they
                // become visible together in the same cycle
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
                read_s  = 1'b0;
                if (timeout_r) begin
                    id_ok_s = 1'b0;
                    ts_ok_s = 1'b0;
                end else begin
                    id_ok_s = (id_value_r == EXPECTED_ID);
                    ts_ok_s = (ts_value_r == EXPECTED_TS);
                end
            end
            default: begin
                state_s = IDLE;
                read_s  = 1'b0;
                addr_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            read_r     <= 1'b0;
            addr_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            id_ok_r    <= 1'b0;
            ts_ok_r    <= 1'b0;
            id_value_r <= 32'd0;
            ts_value_r <= 32'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            read_r     <= read_s;
            addr_r     <= addr_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            id_ok_r    <= id_ok_s;
            ts_ok_r    <= ts_ok_s;
            id_value_r <= id_value_s;
            ts_value_r <= ts_value_s;
            timeout_r  <= timeout_s;
        end
    end

    assign avm_address = addr_r;
    assign avm_read    = read_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_lab7_soc_sysid_checker.sv
// Directed testbench for lab7_soc_sysid_checker. A small slave model
// returns id_word at address 0 and ts_word at address 1; waitrequest is
// driven directly by the stimulus. Outputs are sampled on the falling edge.
module tb_lab7_soc_sysid_checker;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        timeout;

    logic [31:0] id_word;
    logic [31:0] ts_word;

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int done_cnt;

    lab7_soc_sysid_checker #(
        .EXPECTED_ID   (32'd0),
        .EXPECTED_TS   (32'd1522343701),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .id_value       (id_value),
        .ts_value       (ts_value),
        .timeout        (timeout)
    );

    always #5 clock = ~clock;

    assign avm_readdata = avm_address ? ts_word : id_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge of the RD_ID cycle
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts cycles from the RD_ID cycle (=1) until done, bounded
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) begin
            mismatched++;
            $error("FAIL wait_done observed=no_done expected=done_within_40");
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        id_word         = 32'd0;
        ts_word         = 32'd1522343701;

        // Reset state
        #1;
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {27'd0, done, id_ok, ts_ok, timeout, avm_address}, 32'd0);
        check("rst_id_value", id_value, 32'd0);
        check("rst_ts_value", ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Test 1: clean sequence, expected words
        pulse_start();
        check("t1_c1_read", {31'd0, avm_read}, 32'd1);
        check("t1_c1_addr", {31'd0, avm_address}, 32'd0);
        check("t1_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        check("t1_c2_read", {31'd0, avm_read}, 32'd1);
        check("t1_c2_addr", {31'd0, avm_address}, 32'd1);
        check("t1_c2_id_value", id_value, 32'd0);
        @(negedge clock);
        check("t1_c3_read", {31'd0, avm_read}, 32'd0);
        check("t1_c3_busy_done", {30'd0, busy, done}, 32'd2);
        check("t1_c3_ts_value", ts_value, 32'd1522343701);
        @(negedge clock);
        check("t1_c4_done", {31'd0, done}, 32'd1);
        check("t1_c4_busy", {31'd0, busy}, 32'd0);
        check("t1_ok_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
        @(negedge clock);
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);

        // Test 2: wrong timestamp
        ts_word = 32'h12345678;
        pulse_start();
        wait_done(cyc);
        check("t2_latency", cyc, 32'd4);
        check("t2_ts_value", ts_value, 32'h12345678);
        check("t2_ok_flags", {30'd0, id_ok, ts_ok}, 32'd2);
        ts_word = 32'd1522343701;
        @(negedge clock);

        // Test 3: three stalls on the ID read
        avm_waitrequest = 1'b1;
        pulse_start();
        cyc = 1;
        for (int k = 0; k < 3; k++) begin
            check("t3_stall_read", {31'd0, avm_read}, 32'd1);
            check("t3_stall_addr", {31'd0, avm_address}, 32'd0);
            @(negedge clock);
            cyc++;
        end
        check("t3_c4_read", {31'd0, avm_read}, 32'd1);
        check("t3_c4_addr", {31'd0, avm_address}, 32'd0);
        avm_waitrequest = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("t3_latency", cyc, 32'd7);
        check("t3_ok_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
        @(negedge clock);

        // Test 4: waitrequest stuck high
        avm_waitrequest = 1'b1;
        id_word = 32'hDEADBEEF;
        pulse_start();
`ifdef LAB7_SOC_SYSID_CHK_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            check("t4_stall_read", {31'd0, avm_read}, 32'd1);
            @(negedge clock);
        end
        check("t4_read_dropped", {31'd0, avm_read}, 32'd0);
        check("t4_timeout", {31'd0, timeout}, 32'd1);
        @(negedge clock);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_ok_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd1);
        check("t4_id_value_kept", id_value, 32'd0);
        check("t4_ts_value_kept", ts_value, 32'd1522343701);
        avm_waitrequest = 1'b0;
`else
        for (int k = 0; k < 12; k++) begin
            check("t4_stall_read", {31'd0, avm_read}, 32'd1);
            check("t4_timeout_zero", {30'd0, timeout, done}, 32'd0);
            @(negedge clock);
        end
        avm_waitrequest = 1'b0;
        wait_done(cyc);
        check("t4_late_latency", cyc, 32'd4);
        check("t4_id_value", id_value, 32'hDEADBEEF);
        check("t4_ok_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd2);
`endif
        id_word = 32'd0;
        @(negedge clock);
        @(negedge clock);

        // Test 5: second start during RD_TS is ignored
        pulse_start();
        @(negedge clock);
        check("t5_in_rd_ts", {31'd0, avm_address}, 32'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clock);
        end
        check("t5_one_done", done_cnt, 32'd1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        // Test 6: reset during RD_TS
        pulse_start();
        @(negedge clock);
        check("t6_in_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {28'd0, avm_read, avm_address, busy, done}, 32'd0);
        check("t6_rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        check("t6_rst_values", id_value | ts_value, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (done === 1'b1) done_cnt++;
        end
        check("t6_no_done_in_reset", done_cnt, 32'd0);
        reset_n = 1'b1;
        pulse_start();
        check("t6_start_accepted", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("t6_latency", cyc, 32'd4);
        check("t6_ok_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
        check("t6_ts_value", ts_value, 32'd1522343701);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lab7_soc_sysid_checker.md
LAB7_SOC_SYSID_CHECKER -- requirements
Module: lab7_soc_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 0, meaning the 32-bit system ID word expected at slave address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 1522343701, meaning the 32-bit timestamp word expected at slave address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of waitrequest-stalled cycles allowed per read; legal range 1..65535.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that requests a check sequence.
REQ-007 SHALL have port avm_address, output, 1 bit: Avalon-MM master word address.
REQ-008 SHALL have port avm_read, output, 1 bit: Avalon-MM read request.
REQ-009 SHALL have port avm_readdata, input, 32 bits: read data, valid in any cycle where avm_read=1 and avm_waitrequest=0.
REQ-010 SHALL have port avm_waitrequest, input, 1 bit: slave stall.
REQ-011 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-013 SHALL have ports id_ok and ts_ok, outputs, 1 bit each: comparison results, held until the next completion.
REQ-014 SHALL have ports id_value and ts_value, outputs, 32 bits each: captured words, held until the next capture.
REQ-015 SHALL have port timeout, output, 1 bit: set when the last sequence aborted on a stall.

Function
REQ-016 SHALL implement the FSM states IDLE, RD_ID, RD_TS and FIN; all outputs SHALL be registered.
REQ-017 SHALL move from IDLE to RD_ID on start=1, and SHALL ignore start in every other state.
REQ-018 SHALL, in RD_ID, drive avm_read=1 and avm_address=0, and SHALL hold both stable while avm_waitrequest=1.
REQ-019 SHALL, on the RD_ID cycle with avm_waitrequest=0, load id_value from avm_readdata and go to RD_TS.
REQ-020 SHALL, in RD_TS, drive avm_read=1 and avm_address=1, and on avm_waitrequest=0 load ts_value and go to FIN.
REQ-021 SHALL, in FIN, drive avm_read=0 and done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL update id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TS) in the same cycle done=1; compares are full 32-bit and unsigned.
REQ-023 SHALL assert busy in RD_ID, RD_TS and FIN, and SHALL deassert it in IDLE.
REQ-024 SHALL take 4 cycles from start to done with no stalls: start sampled at edge 0, RD_ID at edges 1-2, RD_TS at edges 2-3, done=1 after edge 3. Each stalled cycle adds exactly one cycle.
REQ-025 SHALL drive avm_read=0 in IDLE and FIN, and SHALL never issue back-to-back reads to the same address within one sequence.
REQ-026 SHALL clear timeout on entry to RD_ID.

Reset
REQ-027 SHALL, on reset_n=0, immediately force: state IDLE; avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0; stall counter 0.
REQ-028 SHALL, when reset is asserted mid-sequence, abandon the outstanding read without a done pulse; a start in the first cycle after reset_n rises SHALL be accepted.

Configuration
REQ-029 SHALL gate the stall watchdog with macro LAB7_SOC_SYSID_CHK_TIMEOUT_EN.
REQ-030 SHALL, with the macro defined, count consecutive cycles with avm_read=1 and avm_waitrequest=1 (counter cleared on every accepted read). On reaching TIMEOUT_CYCLES it SHALL drop avm_read, set timeout=1, force id_ok=0 and ts_ok=0, and go to FIN (done pulses); id_value and ts_value SHALL keep their last values.
REQ-031 SHALL, with the macro undefined, have no counter: a stall waits indefinitely and timeout is tied to 0.

Verification
REQ-032 SHALL cover: slave returns 0 then 1522343701 with no stalls, start pulse -> done 4 cycles after start, id_ok=1, ts_ok=1, timeout=0.
REQ-033 SHALL cover: timestamp read returns 0x12345678 -> ts_value=0x12345678, ts_ok=0, id_ok=1.
REQ-034 SHALL cover: 3 waitrequest cycles on the ID read -> address and read held stable, done 7 cycles after start.
REQ-035 SHALL cover: macro defined, TIMEOUT_CYCLES=4, waitrequest stuck high -> avm_read drops after 4 stall cycles, timeout=1, done=1, both ok flags 0.
REQ-036 SHALL cover: a second start during RD_TS -> ignored, exactly one done pulse.
REQ-037 SHALL cover: reset_n pulled low during RD_TS -> all outputs 0 asynchronously, no done pulse, and the next start completes normally.
